// File: rtl/obstacle_scheduler.sv
// Game sequencer for the obstacle datapath: IDLE/PLAYING/OVER control, frame-timed
// round-robin spawning over NUM_SLOTS controllers, score/max score and spawn period.
module obstacle_scheduler #(
    parameter int         NUM_SLOTS   = 4,
    parameter int         INIT_PERIOD = 90,
    parameter int         MIN_PERIOD  = 20,
    parameter int         PERIOD_STEP = 5,
    parameter int         SCORE_STEP  = 10,
    parameter int         X_MAX       = 607,
    parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 start_n,
    input  logic                 collision,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic [1:0]           game_state,
    output logic [NUM_SLOTS-1:0] spawn_trigger,
    output logic [9:0]           spawn_x,
    output logic                 clear_obstacles,
    output logic [9:0]           score,
    output logic [9:0]           max_score,
    output logic [7:0]           spawn_period
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 vsync_q, start_n_q;
    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic [NUM_SLOTS-1:0] trig_q, trig_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic [7:0]           period_q, period_d;
    logic [7:0]           step_cnt_q, step_cnt_d;
    logic                 pending_q, pending_d;
    logic                 clear_q, clear_d;
    logic [9:0]           lfsr_q, lfsr_d;
    logic [9:0]           score_q, score_d;
    logic [9:0]           max_q, max_d;
    logic [9:0]           spawn_x_q, spawn_x_d;

    logic                 frame_tick, start_press, spawn_due;
    logic [9:0]           candidate_x;
    logic [NUM_SLOTS-1:0] dodged;
    logic [CNT_W-1:0]     dodge_cnt;
    logic                 free_found;
    logic [PTR_W-1:0]     free_idx;
    logic [10:0]          score_sum;
    logic [9:0]           score_play;
    logic [7:0]           step_sum, step_play, period_play;

    assign frame_tick  = vsync_q & ~vsync;
    assign start_press = start_n_q & ~start_n;
    assign candidate_x = (lfsr_q <= 10'(X_MAX)) ? lfsr_q : lfsr_q - 10'(X_MAX + 1);

    // Only completions of occupied slots count as dodges.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_dodge
            assign dodged[gi] = slot_done[gi] & busy_q[gi];
        end
    endgenerate

    always_comb begin
        dodge_cnt = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            dodge_cnt = dodge_cnt + CNT_W'(dodged[k]);
        end
    end

    // Circular search for the first free slot starting at the round-robin pointer.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_SLOTS);
            if (!free_found && !busy_q[idx]) begin
                free_found = 1'b1;
                free_idx   = idx;
            end
        end
    end

    always_comb begin
        score_sum   = {1'b0, score_q} + 11'(dodge_cnt);
        score_play  = score_sum[10] ? 10'h3FF : score_sum[9:0];
        step_sum    = step_cnt_q + 8'(dodge_cnt);
        step_play   = step_sum;
        period_play = period_q;
        if (step_sum >= 8'(SCORE_STEP)) begin
            step_play   = step_sum - 8'(SCORE_STEP);
            period_play = (period_q < 8'(MIN_PERIOD + PERIOD_STEP)) ? 8'(MIN_PERIOD)
                                                                   : period_q - 8'(PERIOD_STEP);
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q & ~slot_done;
        trig_d      = '0;
        rr_ptr_d    = rr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        period_d    = period_q;
        step_cnt_d  = step_cnt_q;
        pending_d   = pending_q;
        clear_d     = 1'b0;
        lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        score_d     = score_q;
        max_d       = max_q;
        spawn_x_d   = spawn_x_q;
        spawn_due   = 1'b0;

        case (state_q)
            S_PLAYING: begin
                score_d    = score_play;
                step_cnt_d = step_play;
                period_d   = period_play;
                if (collision) begin
                    state_d   = S_OVER;
                    clear_d   = 1'b1;
                    busy_d    = '0;
                    pending_d = 1'b0;
                    max_d     = (score_play > max_q) ? score_play : max_q;
                end else begin
                    if (frame_tick) begin
                        if (frame_cnt_q == period_q - 8'd1) begin
                            frame_cnt_d = '0;
                            spawn_due   = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                    // A due spawn while one is already pending collapses into it.
                    if (spawn_due || pending_q) begin
                        if (free_found) begin
                            trig_d[free_idx] = 1'b1;
                            busy_d[free_idx] = 1'b1;
                            spawn_x_d        = candidate_x;
                            pending_d        = 1'b0;
                            rr_ptr_d         = (free_idx == PTR_W'(NUM_SLOTS - 1)) ? '0
                                                                                  : free_idx + 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (start_press) begin
                    state_d     = S_PLAYING;
                    score_d     = '0;
                    step_cnt_d  = '0;
                    period_d    = 8'(INIT_PERIOD);
                    frame_cnt_d = '0;
                    pending_d   = 1'b0;
                    busy_d      = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b1;
            start_n_q   <= 1'b1;
            busy_q      <= '0;
            trig_q      <= '0;
            rr_ptr_q    <= '0;
            frame_cnt_q <= '0;
            period_q    <= 8'(INIT_PERIOD);
            step_cnt_q  <= '0;
            pending_q   <= 1'b0;
            clear_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            score_q     <= '0;
            max_q       <= '0;
            spawn_x_q   <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync;
            start_n_q   <= start_n;
            busy_q      <= busy_d;
            trig_q      <= trig_d;
            rr_ptr_q    <= rr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            period_q    <= period_d;
            step_cnt_q  <= step_cnt_d;
            pending_q   <= pending_d;
            clear_q     <= clear_d;
            lfsr_q      <= lfsr_d;
            score_q     <= score_d;
            max_q       <= max_d;
            spawn_x_q   <= spawn_x_d;
        end
    end

    assign game_state      = state_q;
    assign spawn_trigger   = trig_q;
    assign spawn_x         = spawn_x_q;
    assign clear_obstacles = clear_q;
    assign score           = score_q;
    assign max_score       = max_q;
    assign spawn_period    = period_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scenario bench for obstacle_scheduler: randomized frame gaps, slots and batch sizes,
// checked against a transaction-level model of the game rules.
module tb_obstacle_scheduler;
    localparam int         NS    = 4;
    localparam int         INIT  = 90;
    localparam int         MINP  = 20;
    localparam int         PSTEP = 5;
    localparam int         SSTEP = 10;
    localparam int         XMAX  = 607;
    localparam logic [9:0] SEED  = 10'h2A5;

    logic          clk = 1'b0;
    logic          reset, vsync, start_n, collision;
    logic [NS-1:0] slot_done;
    logic [1:0]    game_state;
    logic [NS-1:0] spawn_trigger;
    logic [9:0]    spawn_x, score, max_score;
    logic          clear_obstacles;
    logic [7:0]    spawn_period;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .vsync          (vsync),
        .start_n        (start_n),
        .collision      (collision),
        .slot_done      (slot_done),
        .game_state     (game_state),
        .spawn_trigger  (spawn_trigger),
        .spawn_x        (spawn_x),
        .clear_obstacles(clear_obstacles),
        .score          (score),
        .max_score      (max_score),
        .spawn_period   (spawn_period)
    );

    int passed = 0;
    int total  = 0;

    // Game model, one update per transaction.
    int         m_state, m_score, m_max, m_step, m_period, m_frame, m_rr, m_trig_cnt;
    bit         m_pending;
    bit [3:0]   m_busy;
    logic [9:0] m_lfsr, m_prev;
    int         dut_trig_cnt = 0;

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        m_prev <= m_lfsr;
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && spawn_trigger !== 4'b0000) dut_trig_cnt <= dut_trig_cnt + 1;
    end

    function automatic logic [9:0] cand(input logic [9:0] v);
        return (int'(v) <= XMAX) ? v : 10'(int'(v) - (XMAX + 1));
    endfunction

    function automatic int popc(input bit [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic m_dodge(input bit [3:0] mask);
        int n;
        n = popc(mask & m_busy);
        m_busy = m_busy & ~mask;
        if (m_state == 1) begin
            m_score = (m_score + n > 1023) ? 1023 : m_score + n;
            m_step += n;
            if (m_step >= SSTEP) begin
                m_step  -= SSTEP;
                m_period = (m_period - PSTEP < MINP) ? MINP : m_period - PSTEP;
            end
        end
    endtask

    task automatic m_spawn(output bit [3:0] onehot);
        int i;
        onehot = '0;
        for (int k = 0; k < NS; k++) begin
            i = (m_rr + k) % NS;
            if (onehot == 0 && !m_busy[i]) begin
                onehot[i] = 1'b1;
                m_busy[i] = 1'b1;
                m_rr      = (i + 1) % NS;
            end
        end
        m_pending = (onehot == 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_tick(output bit [3:0] spawned);
        spawned = '0;
        if (m_state == 1) begin
            if (m_frame == m_period - 1) begin
                m_frame = 0;
                if (!m_pending) m_spawn(spawned);
            end else begin
                m_frame = (m_frame + 1) % 256;
            end
        end
        vsync = 1'b0;
        step();
        total++;
        if (spawn_trigger !== spawned)
            $display("FAIL tick_trigger: got %b expected %b", spawn_trigger, spawned);
        else passed++;
        if (spawned != 0) begin
            m_trig_cnt++;
            total++;
            if (spawn_x !== cand(m_prev))
                $display("FAIL spawn_x: got %0d expected %0d", spawn_x, cand(m_prev));
            else passed++;
            $display("spawn slot=%b x=%0d", spawn_trigger, spawn_x);
        end
        vsync = 1'b1;
        step();
    endtask

    task automatic run_frames(input int n, input int gap_max);
        bit [3:0] s;
        repeat (n) begin
            frame_tick(s);
            repeat ($urandom_range(0, gap_max)) step();
        end
    endtask

    task automatic wait_spawn(output bit [3:0] s);
        int n = 0;
        s = '0;
        while (s == 0 && n < 300) begin
            frame_tick(s);
            n++;
        end
    endtask

    task automatic pulse_done(input bit [3:0] mask);
        bit [3:0] exp;
        slot_done = mask;
        step();
        slot_done = '0;
        m_dodge(mask);
        total++;
        if (spawn_trigger !== 4'b0000)
            $display("FAIL done_cycle_trigger: got %b expected 0000", spawn_trigger);
        else passed++;
        exp = '0;
        if (m_state == 1 && m_pending) m_spawn(exp);
        step();
        total++;
        if (spawn_trigger !== exp)
            $display("FAIL pending_trigger: got %b expected %b", spawn_trigger, exp);
        else passed++;
        if (exp != 0) begin
            m_trig_cnt++;
            total++;
            if (spawn_x !== cand(m_prev))
                $display("FAIL pending_spawn_x: got %0d expected %0d", spawn_x, cand(m_prev));
            else passed++;
        end
        total++;
        if (score !== 10'(m_score)) $display("FAIL done_score: got %0d expected %0d", score, m_score);
        else passed++;
        total++;
        if (spawn_period !== 8'(m_period))
            $display("FAIL done_period: got %0d expected %0d", spawn_period, m_period);
        else passed++;
        $display("done mask=%b score=%0d period=%0d trig=%b", mask, score, spawn_period, exp);
    endtask

    task automatic press(input int hold);
        start_n = 1'b0;
        repeat (hold) step();
        start_n = 1'b1;
        step();
        if (m_state != 1) begin
            m_state = 1; m_score = 0; m_step = 0; m_period = INIT;
            m_frame = 0; m_pending = 1'b0; m_busy = '0;
        end
        total++;
        if (game_state !== 2'(m_state)) $display("FAIL press_state: got %0d expected %0d", game_state, m_state);
        else passed++;
        total++;
        if (score !== 10'(m_score)) $display("FAIL press_score: got %0d expected %0d", score, m_score);
        else passed++;
        total++;
        if (max_score !== 10'(m_max)) $display("FAIL press_max: got %0d expected %0d", max_score, m_max);
        else passed++;
        total++;
        if (spawn_period !== 8'(m_period))
            $display("FAIL press_period: got %0d expected %0d", spawn_period, m_period);
        else passed++;
        $display("press hold=%0d state=%0d", hold, game_state);
    endtask

    task automatic collide(input bit [3:0] done_mask, input bit with_tick);
        bit exp_clear;
        collision = 1'b1;
        slot_done = done_mask;
        if (with_tick) vsync = 1'b0;
        exp_clear = (m_state == 1);
        m_dodge(done_mask);
        if (m_state == 1) begin
            if (m_score > m_max) m_max = m_score;
            m_state = 2; m_busy = '0; m_pending = 1'b0;
        end
        step();
        collision = 1'b0;
        slot_done = '0;
        vsync     = 1'b1;
        total++;
        if (spawn_trigger !== 4'b0000) $display("FAIL collide_trigger: got %b expected 0000", spawn_trigger);
        else passed++;
        total++;
        if (game_state !== 2'(m_state)) $display("FAIL collide_state: got %0d expected %0d", game_state, m_state);
        else passed++;
        total++;
        if (clear_obstacles !== exp_clear) $display("FAIL collide_clear: got %b expected %b", clear_obstacles, exp_clear);
        else passed++;
        total++;
        if (max_score !== 10'(m_max)) $display("FAIL collide_max: got %0d expected %0d", max_score, m_max);
        else passed++;
        total++;
        if (score !== 10'(m_score)) $display("FAIL collide_score: got %0d expected %0d", score, m_score);
        else passed++;
        step();
        total++;
        if (clear_obstacles !== 1'b0) $display("FAIL clear_one_pulse: got %b expected 0", clear_obstacles);
        else passed++;
        $display("collide tick=%0d state=%0d score=%0d max=%0d", with_tick, game_state, score, max_score);
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b1; start_n = 1'b1; collision = 1'b0; slot_done = '0;
        m_state = 0; m_score = 0; m_max = 0; m_step = 0; m_period = INIT;
        m_frame = 0; m_rr = 0; m_pending = 1'b0; m_busy = '0; m_trig_cnt = 0;
        repeat (3) step();
        reset = 1'b0;
        step();
        total++; if (game_state !== 2'd0)       $display("FAIL reset_state: got %0d expected 0", game_state);        else passed++;
        total++; if (score !== 10'd0)           $display("FAIL reset_score: got %0d expected 0", score);             else passed++;
        total++; if (max_score !== 10'd0)       $display("FAIL reset_max: got %0d expected 0", max_score);           else passed++;
        total++; if (spawn_period !== 8'(INIT)) $display("FAIL reset_period: got %0d expected %0d", spawn_period, INIT); else passed++;
        total++; if (spawn_trigger !== 4'b0000) $display("FAIL reset_trigger: got %b expected 0000", spawn_trigger); else passed++;
        total++; if (spawn_x !== 10'd0)         $display("FAIL reset_spawn_x: got %0d expected 0", spawn_x);         else passed++;
        total++; if (clear_obstacles !== 1'b0)  $display("FAIL reset_clear: got %b expected 0", clear_obstacles);    else passed++;
        $display("reset released state=%0d period=%0d", game_state, spawn_period);
    endtask

    task automatic test_first_spawn();
        press(1);
        run_frames(INIT, 2);
        run_frames(INIT, 2);
    endtask

    task automatic test_pending();
        int s;
        run_frames(2 * INIT, 1);
        run_frames(INIT, 1);
        run_frames(INIT, 1);
        s = $urandom_range(0, NS - 1);
        pulse_done(4'(1 << s));
        repeat (5) step();
        total++;
        if (dut_trig_cnt !== m_trig_cnt)
            $display("FAIL pending_trig_count: got %0d expected %0d", dut_trig_cnt, m_trig_cnt);
        else passed++;
    endtask

    task automatic test_free_done();
        pulse_done(4'b1111);
        pulse_done(4'($urandom_range(1, 15)));
    endtask

    task automatic test_collision_max();
        bit [3:0] one;
        collide(4'b0000, 1'b0);
        press(4);
        press(1);
        repeat (6) begin
            wait_spawn(one);
            repeat ($urandom_range(0, 2)) step();
            pulse_done(one);
        end
        wait_spawn(one);
        collide(one, 1'b0);
        collide(4'b0000, 1'b0);
        press(1);
    endtask

    task automatic test_collision_spawn();
        bit [3:0] s;
        int n = 0;
        while (m_frame != m_period - 1 && n < 300) begin
            frame_tick(s);
            n++;
        end
        collide(4'b0000, 1'b1);
        pulse_done(4'($urandom_range(1, 15)));
        press(2);
    endtask

    task automatic test_difficulty();
        bit [3:0] mask, one;
        int dodges = 0;
        int k;
        while (dodges < 140) begin
            mask = '0;
            k = $urandom_range(1, 3);
            repeat (k) begin
                wait_spawn(one);
                mask |= one;
            end
            pulse_done(mask);
            dodges += popc(mask);
        end
        total++;
        if (spawn_period !== 8'(MINP)) $display("FAIL period_floor: got %0d expected %0d", spawn_period, MINP);
        else passed++;
        dodges = 0;
        while (dodges < 12) begin
            wait_spawn(one);
            pulse_done(one);
            dodges++;
        end
        total++;
        if (spawn_period !== 8'(MINP)) $display("FAIL period_stays_floor: got %0d expected %0d", spawn_period, MINP);
        else passed++;
        step();
        total++;
        if (dut_trig_cnt !== m_trig_cnt)
            $display("FAIL total_trig_count: got %0d expected %0d", dut_trig_cnt, m_trig_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_pending();
        test_free_done();
        test_collision_max();
        test_collision_spawn();
        test_difficulty();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Game sequencer that owns the obstacle datapath for the HDMI/VGA game. It runs the IDLE/PLAYING/OVER game state machine and times obstacle spawns from frame ticks derived from VGA_VS. It shares NUM_SLOTS obstacle controller slots round-robin, picks a pseudo-random spawn column, and keeps score, max score and a difficulty-scaled spawn period. It sits in top between the player/obstacle controllers and the sprite/colour logic.

Parameters:
NUM_SLOTS, 4, number of obstacle controller instances sharing spawn requests
INIT_PERIOD, 90, frames between spawns at game start (8-bit)
MIN_PERIOD, 20, floor of spawn period in frames
PERIOD_STEP, 5, frames removed from period per difficulty step
SCORE_STEP, 10, dodged obstacles per difficulty step
X_MAX, 607, largest legal spawn x (640 - 32 sprite width - 1)
LFSR_SEED, 10'h2A5, nonzero LFSR reset value

Ports:
CLOCK_50  in  1  system clock, 50 MHz; only clock
reset  in  1  synchronous, active-high reset
vsync  in  1  VGA_VS, active-low sync pulse
start_n  in  1  start key, active low (KEY[2])
collision  in  1  player/obstacle overlap, level, sampled every clock
slot_done  in  NUM_SLOTS  one-cycle pulse per slot: obstacle left bottom of screen
game_state  out  2  0=IDLE, 1=PLAYING, 2=OVER
spawn_trigger  out  NUM_SLOTS  one-hot, one-cycle spawn command
spawn_x  out  10  spawn column, valid while spawn_trigger nonzero
clear_obstacles  out  1  one-cycle pulse: all slots must despawn
score  out  10  current score, saturates at 1023
max_score  out  10  best score since reset
spawn_period  out  8  current period in frames

Behaviour:
- Reset, all outputs and state: game_state=IDLE; spawn_trigger=0; spawn_x=0; clear_obstacles=0; score=0; max_score=0; spawn_period=INIT_PERIOD; busy=0; rr_ptr=0; frame_cnt=0; pending=0; lfsr=LFSR_SEED. Reset overrides any operation in progress.
- frame_tick: registered vsync_d, tick = vsync_d & ~vsync, one cycle per frame.
- start_press: registered start_n_d, press = start_n_d & ~start_n. A held key gives a single press.
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1, advances every clock in every state. Candidate x = lfsr when lfsr <= X_MAX, else lfsr - (X_MAX+1).
- FSM transitions:
  - IDLE --press--> PLAYING
  - PLAYING --collision--> OVER
  - OVER --press--> PLAYING
  - No other transitions.
- On entry to PLAYING: score=0, step_cnt=0, spawn_period=INIT_PERIOD, frame_cnt=0, pending=0, busy=0.
- On PLAYING->OVER: clear_obstacles pulses in the next cycle; busy=0; pending=0; max_score=max(max_score, score) in the same cycle.
- Spawn timing (PLAYING only):
  - frame_cnt increments on tick.
  - On a tick with frame_cnt==spawn_period-1: frame_cnt=0 and a spawn becomes due.
- Slot selection:
  - The first free slot at or after rr_ptr, searched circularly using registered busy.
  - If one is found: spawn_trigger[slot]=1 and spawn_x=candidate in the next cycle; busy[slot]=1; rr_ptr=slot+1 mod NUM_SLOTS.
  - If none is free: pending=1. The pending spawn is issued on the first cycle a slot is free. frame_cnt keeps running.
  - A spawn that comes due while pending=1 is dropped; at most one spawn is pending.
- slot_done[i]:
  - Clears busy[i] in any state.
  - In PLAYING only, score += popcount of pulses on busy slots, saturating at 1023.
  - Pulses on already-free slots are ignored and add no score.
- Difficulty:
  - step_cnt += n (dodges counted this cycle).
  - When the sum >= SCORE_STEP: step_cnt = sum - SCORE_STEP and spawn_period = max(MIN_PERIOD, spawn_period - PERIOD_STEP), with no unsigned underflow.
- Simultaneous events:
  - Collision beats spawn: no spawn_trigger in that cycle.
  - slot_done scored in the same cycle as collision still counts before max_score is compared.
  - Collision in IDLE/OVER is ignored. press while in PLAYING is ignored.
- Latency:
  - tick to spawn_trigger: 1 clock.
  - collision to game_state=OVER: 1 clock.
  - press edge to PLAYING: 1 clock after the edge is registered.

Test Plan:
- reset held 3 clocks, then released -> game_state=0, score=0, spawn_period=90, spawn_trigger=0, lfsr=10'h2A5.
- press start_n, apply 90 vsync falling edges -> exactly one spawn_trigger=4'b0001 one clock after the 90th tick, spawn_x<=607; next spawn 90 frames later on 4'b0010.
- keep all 4 slots busy, let a spawn come due, then pulse slot_done[2] -> trigger 4'b0100 on the first cycle slot 2 is free; a second due spawn while pending is dropped; score=1.
- 10 dodges with NUM_SLOTS recycled -> spawn_period 90->85; 140 dodges total -> period clamps at 20 and never goes below it.
- collision while score=7 and max_score=3 -> OVER next clock, clear_obstacles one pulse, max_score=7; a second press -> PLAYING with score=0 and max_score still 7.
- collision and due spawn in the same cycle -> no spawn_trigger; slot_done pulses on free slots -> score unchanged.
